// File: rtl/mux_arb_pkg.sv
// Shared types and the round-robin pick function for the 4:1 mux arbiter.
// The hold-timeout feature in the arbiter is enabled with ARB_TIMEOUT_EN.
package mux_arb_pkg;

    localparam int N_REQ = 4;

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } arb_state_t;

    typedef logic [1:0] sel_t;

    // First set request scanning upward from ptr+1 with wrap; ptr itself has lowest priority.
    function automatic sel_t rr_pick(input logic [N_REQ-1:0] req, input sel_t ptr);
        sel_t idx;
        logic found;
        rr_pick = ptr;
        found   = 1'b0;
        for (int i = 1; i <= N_REQ; i++) begin
            idx = ptr + sel_t'(i);
            if (!found && req[idx]) begin
                rr_pick = idx;
                found   = 1'b1;
            end
        end
    endfunction

    function automatic logic [N_REQ-1:0] onehot(input sel_t idx);
        onehot      = '0;
        onehot[idx] = 1'b1;
    endfunction

endpackage

// File: rtl/mux_4x1_v2.sv
// Plain case-based 4:1 bit multiplexer; select is {s0,s1} with s0 as MSB.
module mux_4x1_v2 (
    input  logic [3:0] x,
    input  logic       s0,
    input  logic       s1,
    output logic       y
);

    always_comb begin
        y = 1'b0;
        case ({s0, s1})
            2'b00: y = x[0];
            2'b01: y = x[1];
            2'b10: y = x[2];
            2'b11: y = x[3];
            default: y = 1'b0;
        endcase
    end

endmodule

// File: rtl/mux_4x1_rr_arbiter.sv
// Round-robin arbiter sharing one 4:1 bit mux among four requesters.
// Define ARB_TIMEOUT_EN to force a handover after MAX_HOLD consecutive owned cycles.
//
// state | meaning
// IDLE  | no grant active; waiting for any request
// GRANT | one requester owns the mux; gnt/select/valid asserted
module mux_4x1_rr_arbiter
    import mux_arb_pkg::*;
#(
    parameter int MAX_HOLD = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [N_REQ-1:0] req,
    input  logic [N_REQ-1:0] x,
    output logic [N_REQ-1:0] gnt,
    output logic             s0,
    output logic             s1,
    output logic             valid,
    output logic             f
);

    if (MAX_HOLD < 2 || MAX_HOLD > 255) begin : g_bad_max_hold
        $error("MAX_HOLD out of range 2..255");
    end

    arb_state_t       state, nxt_state;
    sel_t             sel, nxt_sel;
    sel_t             ptr, nxt_ptr;
    logic [N_REQ-1:0] gnt_q, nxt_gnt;
    logic [N_REQ-1:0] others;
    logic             owner_req;
    logic             hold_expired;
    sel_t             pick_idle, pick_other;
    logic             mux_y;

`ifdef ARB_TIMEOUT_EN
    localparam logic [7:0] HOLD_LAST = 8'(MAX_HOLD - 1);
    logic [7:0] cnt, nxt_cnt;
    assign hold_expired = (cnt == HOLD_LAST);
`else
    assign hold_expired = 1'b0;
`endif

    // Owner is excluded from the handover pick so a timeout never re-picks itself.
    assign owner_req  = req[sel];
    assign others     = req & ~onehot(sel);
    assign pick_idle  = rr_pick(req, ptr);
    assign pick_other = rr_pick(others, sel);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
            sel   <= 2'd0;
            ptr   <= 2'd3;
            gnt_q <= '0;
`ifdef ARB_TIMEOUT_EN
            cnt   <= '0;
`endif
        end else begin
            state <= nxt_state;
            sel   <= nxt_sel;
            ptr   <= nxt_ptr;
            gnt_q <= nxt_gnt;
`ifdef ARB_TIMEOUT_EN
            cnt   <= nxt_cnt;
`endif
        end
    end

    always_comb begin
        nxt_state = state;
        nxt_sel   = sel;
        nxt_ptr   = ptr;
        nxt_gnt   = gnt_q;
`ifdef ARB_TIMEOUT_EN
        nxt_cnt   = cnt;
`endif
        case (state)
            IDLE: begin
                if (|req) begin
                    nxt_state = GRANT;
                    nxt_sel   = pick_idle;
                    nxt_ptr   = pick_idle;
                    nxt_gnt   = onehot(pick_idle);
`ifdef ARB_TIMEOUT_EN
                    nxt_cnt   = '0;
`endif
                end
            end
            GRANT: begin
                if (owner_req && !hold_expired) begin
`ifdef ARB_TIMEOUT_EN
                    if (cnt != 8'hFF) nxt_cnt = cnt + 8'd1;
`endif
                end else if (|others) begin
                    nxt_sel = pick_other;
                    nxt_ptr = pick_other;
                    nxt_gnt = onehot(pick_other);
`ifdef ARB_TIMEOUT_EN
                    nxt_cnt = '0;
`endif
                end else if (owner_req) begin
`ifdef ARB_TIMEOUT_EN
                    nxt_cnt = '0;
`endif
                end else begin
                    // Select deliberately keeps its last value when going idle.
                    nxt_state = IDLE;
                    nxt_gnt   = '0;
`ifdef ARB_TIMEOUT_EN
                    nxt_cnt   = '0;
`endif
                end
            end
            default: begin
                nxt_state = IDLE;
                nxt_gnt   = '0;
            end
        endcase
    end

    mux_4x1_v2 u_mux (
        .x  (x),
        .s0 (sel[1]),
        .s1 (sel[0]),
        .y  (mux_y)
    );

    always_comb begin
        valid = (state == GRANT);
        gnt   = gnt_q;
        s0    = sel[1];
        s1    = sel[0];
        f     = valid & mux_y;
    end

endmodule

// File: tb/tb_mux_4x1_rr_arbiter.sv
// Directed self-checking bench for the round-robin 4:1 mux arbiter.
module tb_mux_4x1_rr_arbiter;

    logic       clk = 1'b0;
    logic       reset;
    logic [3:0] req;
    logic [3:0] x;
    logic [3:0] gnt;
    logic       s0, s1, valid, f;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    mux_4x1_rr_arbiter #(.MAX_HOLD(4)) dut (
        .clk   (clk),
        .reset (reset),
        .req   (req),
        .x     (x),
        .gnt   (gnt),
        .s0    (s0),
        .s1    (s1),
        .valid (valid),
        .f     (f)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        req   = 4'b0000;
        x     = 4'b0000;
        reset = 1'b1;
        tick();
        reset = 1'b0;
        #1;
    endtask

    task automatic test_reset();
        do_reset();
        reset = 1'b1;
        #1;
        checks++; if (gnt !== 4'b0000) begin errors++; $display("FAIL reset_gnt: got %b expected %b", gnt, 4'b0000); end
        checks++; if ({s0, s1} !== 2'b00) begin errors++; $display("FAIL reset_sel: got %b expected %b", {s0, s1}, 2'b00); end
        checks++; if (valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b expected %b", valid, 1'b0); end
        reset = 1'b0;
        req   = 4'b0100;
        x     = 4'b0100;
        tick();
        checks++; if (gnt !== 4'b0100) begin errors++; $display("FAIL first_grant: got %b expected %b", gnt, 4'b0100); end
        checks++; if (f !== 1'b1) begin errors++; $display("FAIL first_grant_f: got %b expected %b", f, 1'b1); end
        // async assert mid-grant, checked without a clock edge
        reset = 1'b1;
        #1;
        checks++; if (gnt !== 4'b0000) begin errors++; $display("FAIL async_rst_gnt: got %b expected %b", gnt, 4'b0000); end
        checks++; if (valid !== 1'b0) begin errors++; $display("FAIL async_rst_valid: got %b expected %b", valid, 1'b0); end
        checks++; if (f !== 1'b0) begin errors++; $display("FAIL async_rst_f: got %b expected %b", f, 1'b0); end
        #2;
        reset = 1'b0;
        tick();
        checks++; if (gnt !== 4'b0100) begin errors++; $display("FAIL post_rst_gnt: got %b expected %b", gnt, 4'b0100); end
        checks++; if ({s0, s1} !== 2'b10) begin errors++; $display("FAIL post_rst_sel: got %b expected %b", {s0, s1}, 2'b10); end
        req = 4'b0000;
        tick();
        checks++; if (valid !== 1'b0) begin errors++; $display("FAIL idle_valid: got %b expected %b", valid, 1'b0); end
        checks++; if ({s0, s1} !== 2'b10) begin errors++; $display("FAIL idle_sel_kept: got %b expected %b", {s0, s1}, 2'b10); end
    endtask

    task automatic test_round_robin();
        logic [3:0] req_seq [5];
        logic [3:0] exp_seq [5];
        req_seq = '{4'b1111, 4'b1110, 4'b1101, 4'b1011, 4'b0111};
        exp_seq = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
        do_reset();
        for (int k = 0; k < 5; k++) begin
            req = req_seq[k];
            tick();
            checks++; if (gnt !== exp_seq[k]) begin errors++; $display("FAIL rr_gnt[%0d]: got %b expected %b", k, gnt, exp_seq[k]); end
            checks++; if (valid !== 1'b1) begin errors++; $display("FAIL rr_valid[%0d]: got %b expected %b", k, valid, 1'b1); end
        end
        req = 4'b1111;
        tick();
        checks++; if (gnt !== 4'b0001) begin errors++; $display("FAIL rr_hold: got %b expected %b", gnt, 4'b0001); end
    endtask

    task automatic test_datapath();
        do_reset();
        req = 4'b0010;
        tick();
        checks++; if (gnt !== 4'b0010) begin errors++; $display("FAIL dp_gnt: got %b expected %b", gnt, 4'b0010); end
        checks++; if ({s0, s1} !== 2'b01) begin errors++; $display("FAIL dp_sel: got %b expected %b", {s0, s1}, 2'b01); end
        x = 4'b0010;
        #1;
        checks++; if (f !== 1'b1) begin errors++; $display("FAIL dp_f_one: got %b expected %b", f, 1'b1); end
        x = 4'b1101;
        #1;
        checks++; if (f !== 1'b0) begin errors++; $display("FAIL dp_f_zero: got %b expected %b", f, 1'b0); end
        req = 4'b0000;
        tick();
        x = 4'b1111;
        #1;
        checks++; if (valid !== 1'b0) begin errors++; $display("FAIL dp_idle_valid: got %b expected %b", valid, 1'b0); end
        checks++; if (f !== 1'b0) begin errors++; $display("FAIL dp_idle_f: got %b expected %b", f, 1'b0); end
    endtask

    task automatic test_wrap();
        do_reset();
        req = 4'b1001;
        tick();
        checks++; if (gnt !== 4'b0001) begin errors++; $display("FAIL wrap_gnt: got %b expected %b", gnt, 4'b0001); end
        req = 4'b0001;
        tick();
        checks++; if (gnt !== 4'b0001) begin errors++; $display("FAIL wrap_hold: got %b expected %b", gnt, 4'b0001); end
        req = 4'b1000;
        tick();
        checks++; if (gnt !== 4'b1000) begin errors++; $display("FAIL simul_gnt: got %b expected %b", gnt, 4'b1000); end
        checks++; if ({s0, s1} !== 2'b11) begin errors++; $display("FAIL simul_sel: got %b expected %b", {s0, s1}, 2'b11); end
        req = 4'b0110;
        tick();
        checks++; if (gnt !== 4'b0010) begin errors++; $display("FAIL wrap_from3: got %b expected %b", gnt, 4'b0010); end
    endtask

`ifdef ARB_TIMEOUT_EN
    task automatic test_timeout();
        logic [3:0] exp;
        do_reset();
        req = 4'b0011;
        for (int k = 0; k < 16; k++) begin
            tick();
            exp = (((k / 4) % 2) == 0) ? 4'b0001 : 4'b0010;
            checks++; if (gnt !== exp) begin errors++; $display("FAIL timeout_alt[%0d]: got %b expected %b", k, gnt, exp); end
        end
        do_reset();
        req = 4'b0001;
        for (int k = 0; k < 12; k++) begin
            tick();
            checks++; if (gnt !== 4'b0001) begin errors++; $display("FAIL timeout_solo[%0d]: got %b expected %b", k, gnt, 4'b0001); end
        end
    endtask
`else
    task automatic test_hold();
        do_reset();
        req = 4'b0011;
        for (int k = 0; k < 20; k++) begin
            tick();
            checks++; if (gnt !== 4'b0001) begin errors++; $display("FAIL hold[%0d]: got %b expected %b", k, gnt, 4'b0001); end
        end
    endtask
`endif

    initial begin
        reset = 1'b1;
        req   = 4'b0000;
        x     = 4'b0000;
        #1;
        checks++; if (gnt !== 4'b0000) begin errors++; $display("FAIL init_gnt: got %b expected %b", gnt, 4'b0000); end
        test_reset();
        test_round_robin();
        test_datapath();
        test_wrap();
`ifdef ARB_TIMEOUT_EN
        test_timeout();
`else
        test_hold();
`endif
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/mux_4x1_rr_arbiter.md
Name: mux_4x1_rr_arbiter

Overview:
- Round-robin arbiter that shares one 4:1 bit multiplexer among four requesters.
- Registers a one-hot grant and the matching 2-bit select ({s0,s1} order, s0 = MSB), and drives the muxed bit out.
- Sits between four single-bit sources and one shared consumer; it is the sequencing layer for the combinational 4:1 mux.

Parameters:
- MAX_HOLD, 8, maximum consecutive cycles one requester may own the mux (timeout feature only); legal range 2..255.

Ports:
- clk  input  1  rising-edge clock
- reset  input  1  asynchronous, active-high reset
- req  input  4  request per source; req[i] belongs to x[i]
- x  input  4  data bit per source
- gnt  output  4  registered one-hot grant; all zero when idle
- s0  output  1  registered select MSB
- s1  output  1  registered select LSB
- valid  output  1  registered; high when a grant is active
- f  output  1  x[{s0,s1}] when valid, else 0 (combinational from registered select)

Behaviour:
- Reset (async assert, sync release): gnt=0000, {s0,s1}=00, valid=0, f=0, state=IDLE, last-grant pointer=3, hold counter=0.
- State machine, two states:
  - IDLE: if req==0, stay. Otherwise pick the first set req[i] scanning from (pointer+1) mod 4 upward with wrap. Next edge: gnt=onehot(i), {s0,s1}=i, valid=1, pointer=i, counter=0, state=GRANT.
  - GRANT, owner still requesting (req[owner]=1, no timeout): hold gnt and select; counter increments, saturating.
  - GRANT, owner drops req (or timeout), at least one other req set: switch directly to the next winner in round-robin order from the owner. No idle bubble; the new gnt appears on that same edge.
  - GRANT, owner drops req and no other req set: next edge gnt=0000, valid=0, state=IDLE. Select keeps its last value.
- Latency: the first grant comes 1 cycle after req rises from idle. A handover takes 1 cycle after the owner's req falls.
- Owner drop and a new request in the same cycle: the new request takes part in the pick on that edge.
- Requests that rise while another source owns the mux wait. Each waiting requester is served within 3 ownership periods.
- f is combinational in x: f=x[{s0,s1}] when valid=1, forced 0 when valid=0.
- gnt is always one-hot or zero, and valid is always equal to |gnt.
- Reset asserted mid-grant: outputs go to reset values immediately, without waiting for a clock edge.

Optional Feature:
- Macro: ARB_TIMEOUT_EN
- Defined: when counter reaches MAX_HOLD-1 while req[owner] is still high, the arbiter forces a handover.
  - With other requesters set: move to the next round-robin winner.
  - With no other requesters: the same owner keeps the grant and the counter restarts at 0.
- Undefined: no counter logic; the owner holds the grant for as long as its req stays high.

Decomposition:
- Package mux_arb_pkg:
  - typedef enum logic {IDLE, GRANT} arb_state_t
  - typedef logic [1:0] sel_t
  - constant N_REQ=4
  - function rr_pick(req, ptr) returning sel_t
- Sub-module mux_4x1_v2 (existing case-based 4:1 mux) is instantiated for the f datapath. The valid gating sits outside it.

Test Plan:
- Reset behaviour: assert reset mid-grant with req=0100 -> gnt=0000, valid=0, f=0 with no clock edge; after release with req=0100 -> gnt=0100, {s0,s1}=10 one cycle later.
- Round-robin order: req=1111 held, each owner drops req for one cycle in turn -> grant order 0001, 0010, 0100, 1000, 0001 with no idle cycle between handovers.
- Datapath: gnt=0010 active, x=0010 -> f=1; x=1101 -> f=0; then req=0000 -> valid=0, f=0 even with x=1111.
- Wrap and simultaneous events: pointer=3, req=1001 -> grant 0001. While 0001 is owned, req[3] rises in the same cycle req[0] falls -> next gnt=1000.
- Timeout, ARB_TIMEOUT_EN defined with MAX_HOLD=4: req=0011 held constant -> gnt alternates 0001/0010 every 4 cycles. With req=0001 only -> gnt stays 0001 and the counter restarts.
- Hold without timeout, ARB_TIMEOUT_EN undefined: req=0011 held for 20 cycles -> gnt stays 0001 for all 20 cycles.
